// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed driver for an 8-digit, active-low, seven-segment display.
// The scan walks digits 0..7. Each digit gets a slot of CLK_DIV cycles, and
// the first BLANK_CYCLES cycles of every slot keep all anodes dark.
//
// Writes land in a pending buffer. The buffer is copied to the active
// registers only at the frame boundary (last cycle of digit 7). Because of
// this, a frame never mixes old and new contents.
//
// Write handshake:
//   - A write is taken on any rising edge where wr_en=1 and wr_ready=1.
//   - wr_ready is low while a write waits in the pending buffer.
//   - wr_en is ignored while wr_ready is low. It has no side effects then.

module seg_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dots,
    input  logic [7:0]  wr_mask,
    output logic        wr_ready,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick,
    output logic        dbg_state_o
);

    // Prescaler sizing: CLK_DIV is at least BLANK_CYCLES+2, so the width is
    // always at least 2 bits and BLANK_CYCLES fits in the same width.
    localparam int              CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    // Update FSM encoding: IDLE accepts writes, PENDING holds one write.
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             slot_end;
    logic             frame_end;

    // Update FSM and buffers
    logic             state_q, state_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [7:0]       pend_dots_q, pend_dots_d;
    logic [7:0]       pend_mask_q, pend_mask_d;
    logic [31:0]      act_data_q, act_data_d;
    logic [7:0]       act_dots_q, act_dots_d;
    logic [7:0]       act_mask_q, act_mask_d;

    // Registered outputs
    logic             wr_ready_q, wr_ready_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    // Current digit's view of the active registers
    logic [3:0]       cur_nibble;
    logic             cur_dot;
    logic             cur_en;

    // Hex nibble to segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign slot_end  = (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (idx_q == 3'd7);

    // Prescaler and digit index: the index advances when the slot counter wraps.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Update FSM. Capture into pending when idle; hand over to active at the
    // frame boundary. A write taken on the boundary cycle itself only reaches
    // pending and waits for the next boundary.
    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_dots_d = pend_dots_q;
        pend_mask_d = pend_mask_q;
        act_data_d  = act_data_q;
        act_dots_d  = act_dots_q;
        act_mask_d  = act_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    pend_data_d = wr_data;
                    pend_dots_d = wr_dots;
                    pend_mask_d = wr_mask;
                    state_d     = ST_PENDING;
                end
            end
            default: begin
                if (frame_end) begin
                    act_data_d = pend_data_q;
                    act_dots_d = pend_dots_q;
                    act_mask_d = pend_mask_q;
                    state_d    = ST_IDLE;
                end
            end
        endcase
        wr_ready_d = (state_d == ST_IDLE);
    end

    assign cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];
    assign cur_dot    = act_dots_q[idx_q];
    assign cur_en     = act_mask_q[idx_q];

    // Display decode from the active registers only. At most one anode is
    // driven low because it is derived from the single index.
    always_comb begin
        an_d         = 8'hFF;
        seg_d        = 8'hFF;
        frame_tick_d = frame_end;
        if ((cnt_q >= BLANK_LIM) && cur_en) begin
            an_d  = ~(8'b0000_0001 << idx_q);
            seg_d = {~cur_dot, glyph(cur_nibble)};
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // FSM state with pending and active buffers. Reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_data_q <= '0;
            pend_dots_q <= '0;
            pend_mask_q <= '0;
            act_data_q  <= '0;
            act_dots_q  <= '0;
            act_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_data_q <= pend_data_d;
            pend_dots_q <= pend_dots_d;
            pend_mask_q <= pend_mask_d;
            act_data_q  <= act_data_d;
            act_dots_q  <= act_dots_d;
            act_mask_q  <= act_mask_d;
        end
    end

    // Output registers: display is dark and writes are open while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready_q   <= 1'b1;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            wr_ready_q   <= wr_ready_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_tick  = frame_tick_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
// A reference model predicts every cycle's outputs. Each prediction is
// pushed onto exp_q when the inputs are driven, and popped and compared
// one edge later.

module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_dots = '0;
  logic [7:0]  wr_mask = '0;
  logic        wr_ready;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;
  logic        dbg_state;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_dots     (wr_dots),
    .wr_mask     (wr_mask),
    .wr_ready    (wr_ready),
    .an          (an),
    .seg         (seg),
    .frame_tick  (frame_tick),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  logic [17:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          m_t = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_data = '0, p_data = '0;
  logic [7:0]  m_dots = '0, p_dots = '0;
  logic [7:0]  m_mask = '0, p_mask = '0;

  // per-window statistics
  int         n_lit, n_ft, n_w0, n_w1;
  logic [7:0] w0_an, w0_seg, w1_an, w1_seg;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pend = 1'b0;
    m_data = '0; m_dots = '0; m_mask = '0;
    p_data = '0; p_dots = '0; p_mask = '0;
  endtask

  // Predict outputs after the coming edge and advance the model by one cycle.
  task automatic model_edge(input logic en, input logic [31:0] d, input logic [7:0] dt, input logic [7:0] mk);
    int c, ix;
    logic [3:0] nib;
    logic [7:0] an_e, seg_e;
    logic bnd;
    c  = m_t % CLK_DIV;
    ix = (m_t / CLK_DIV) % 8;
    an_e = 8'hFF;
    seg_e = 8'hFF;
    if (c >= BLANK && m_mask[ix]) begin
      an_e[ix] = 1'b0;
      nib = m_data[ix*4 +: 4];
      seg_e = {~m_dots[ix], glyph_tab[nib]};
    end
    bnd = (c == CLK_DIV - 1) && (ix == 7);
    if (m_pend && bnd) begin
      m_data = p_data; m_dots = p_dots; m_mask = p_mask;
      m_pend = 1'b0;
    end else if (!m_pend && en) begin
      p_data = d; p_dots = dt; p_mask = mk;
      m_pend = 1'b1;
    end
    exp_q.push_back({an_e, seg_e, bnd, ~m_pend});
    m_t++;
  endtask

  task automatic clear_stats();
    n_lit = 0; n_ft = 0; n_w0 = 0; n_w1 = 0;
    w0_an = 8'h00; w0_seg = 8'h00; w1_an = 8'h00; w1_seg = 8'h00;
  endtask

  // driver: one clock cycle with the given inputs, then check the outputs
  task automatic step(input logic en, input logic [31:0] d, input logic [7:0] dt, input logic [7:0] mk);
    logic [17:0] e;
    wr_en = en; wr_data = d; wr_dots = dt; wr_mask = mk;
    model_edge(en, d, dt, mk);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("an", an, e[17:10]);
    check("seg", seg, e[9:2]);
    check("frame_tick", frame_tick, e[1]);
    check("wr_ready", wr_ready, e[0]);
    check("an_one_cold", ($countones(~an) <= 1), 1);
    if (an != 8'hFF) n_lit++;
    if (frame_tick) n_ft++;
    if (an == w0_an && seg == w0_seg) n_w0++;
    if (an == w1_an && seg == w1_seg) n_w1++;
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an, 8'hFF);
    check({tag, "_seg"}, seg, 8'hFF);
    check({tag, "_ready"}, wr_ready, 1'b1);
    check({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  initial begin
    clear_stats();
    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // idle scan: three dark frames, one tick per frame
    run(192);
    check("idle_lit", n_lit, 0);
    check("idle_ticks", n_ft, 3);

    // full write, held until the boundary, shown in the next frame
    clear_stats();
    step(1'b1, 32'h89AB_CDEF, 8'h01, 8'hFF);
    check("ready_low_after_write", wr_ready, 1'b0);
    run(63);
    check("pre_transfer_lit", n_lit, 0);
    clear_stats();
    w0_an = 8'hFE; w0_seg = 8'h0E;
    w1_an = 8'h7F; w1_seg = 8'h80;
    run(64);
    check("full_lit", n_lit, 48);
    check("digit0_FE_0E", n_w0, 6);
    check("digit7_7F_80", n_w1, 6);

    // single digit write, second write while pending is ignored
    clear_stats();
    step(1'b1, 32'h0000_0500, 8'h00, 8'h04);
    step(1'b1, 32'hFFFF_FFFF, 8'hFF, 8'hFF);
    run(62);
    check("old_frame_lit", n_lit, 48);
    clear_stats();
    w0_an = 8'hFB; w0_seg = 8'h92;
    run(64);
    check("mask_lit", n_lit, 6);
    check("digit2_FB_92", n_w0, 6);

    // write accepted on the boundary cycle waits one more frame
    clear_stats();
    w0_an = 8'hFB; w0_seg = 8'h92;
    run(63);
    step(1'b1, 32'h1234_5678, 8'h00, 8'hFF);
    check("boundary_write_ready", wr_ready, 1'b0);
    check("pre_boundary_lit", n_lit, 6);
    clear_stats();
    w0_an = 8'hFB; w0_seg = 8'h92;
    run(64);
    check("unchanged_lit", n_lit, 6);
    check("unchanged_FB_92", n_w0, 6);
    clear_stats();
    w0_an = 8'hFE; w0_seg = 8'h80;
    w1_an = 8'h7F; w1_seg = 8'hF9;
    run(64);
    check("late_lit", n_lit, 48);
    check("late_digit0", n_w0, 6);
    check("late_digit7", n_w1, 6);

    // random writes over four frames
    for (int i = 0; i < 255; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    run(1);

    // reset during PENDING at digit 3
    step(1'b1, 32'hAAAA_AAAA, 8'hFF, 8'hFF);
    run(27);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_stats();
    run(64);
    check("post_reset_lit", n_lit, 0);
    check("post_reset_ticks", n_ft, 1);
    clear_stats();
    step(1'b1, 32'hFEDC_BA98, 8'h00, 8'h01);
    run(63);
    check("post_reset_pre_lit", n_lit, 0);
    clear_stats();
    w0_an = 8'hFE; w0_seg = 8'h80;
    run(64);
    check("post_reset_lit2", n_lit, 6);
    check("post_reset_digit0", n_w0, 6);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
